uncached_dbus_bridge: RTL and testbench

- Sits behind the address-translation stage on the data side.
- Takes translated uncached load/store requests (physical address, access width, store data) from the LSU and performs exactly one transaction on the SoC SRAM-like bus (addr_ok/data_ok handshake).
- Returns lane-aligned, sign- or zero-extended load data, or an error, to the pipeline.
- Generates store byte strobes and replicates store data across byte lanes.

---
 rtl/uncached_dbus_bridge.sv | 246 ++++++++++++++++++++++++
 tb/tb_uncached_dbus_bridge.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uncached_dbus_bridge.sv
// uncached_dbus_bridge
// Bridges one translated uncached load/store from the LSU onto the SoC
// SRAM-like data bus (addr_ok/data_ok handshake) and returns the extended
// load data or an error.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      LSU request handshake (ready only in IDLE)
//   req_wr/req_signed        store flag, load sign-extension flag
//   req_width                00/01 byte, 10 half, 11 word
//   req_paddr/req_wdata      physical byte address, right-justified store data
//   req_kill                 pipeline flush
//   resp_valid/resp_err      one-cycle completion pulse and its error flag
//   resp_rdata               extended load data (0 for stores and errors)
//   bus_req..bus_wdata       bus request channel
//   bus_addr_ok/bus_data_ok  bus address-accept and data-complete strobes
//   bus_rdata                word-lane aligned read data
module uncached_dbus_bridge #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic        req_signed,
    input  logic [1:0]  req_width,
    input  logic [31:0] req_paddr,
    input  logic [31:0] req_wdata,
    input  logic        req_kill,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_RESP = 3'd3,
        ST_DROP = 3'd4
    } state_t;

    // Timeout fires in the cycle whose count is the last allowed one, so the
    // error response appears exactly TIMEOUT_CYCLES cycles after entering ADDR.
    localparam logic            TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state_q, state_d;
    logic            wr_q, wr_d;
    logic            signed_q, signed_d;
    logic [1:0]      size_q, size_d;
    logic [31:0]     addr_q, addr_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            timeout_s;

    function automatic logic misaligned_f(input logic [1:0] width, input logic [1:0] a);
        case (width)
            2'b10:   return a[0];
            2'b11:   return (a != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] size_f(input logic [1:0] width);
        case (width)
            2'b10:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] wstrb_f(input logic wr, input logic [1:0] size,
                                           input logic [1:0] a);
        if (!wr) begin
            return 4'b0000;
        end else begin
            case (size)
                2'd0:    return 4'(4'b0001 << a);
                2'd1:    return 4'(4'b0011 << a);
                default: return 4'b1111;
            endcase
        end
    endfunction

    function automatic logic [31:0] wdata_f(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'd0:    return {4{d[7:0]}};
            2'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_f(input logic [31:0] rd, input logic [1:0] a,
                                           input logic [1:0] size, input logic sgn);
        logic [31:0] sh;
        sh = rd >> {a, 3'b000};
        case (size)
            2'd0:    return {{24{sgn & sh[7]}}, sh[7:0]};
            2'd1:    return {{16{sgn & sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    assign timeout_s  = TO_EN && (to_q == TO_LAST);

    assign req_ready  = (state_q == ST_IDLE);
    assign bus_req    = (state_q == ST_ADDR);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = err_q;
    assign resp_rdata = rdata_q;
    assign bus_wr     = wr_q;
    assign bus_size   = size_q;
    assign bus_addr   = addr_q;
    assign bus_wstrb  = wstrb_q;
    assign bus_wdata  = wdata_q;

    // Next-state, request latch, timeout counter and response registers.
    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        signed_d = signed_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        to_d     = to_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        case (state_q)
            ST_IDLE: begin
                to_d = {TO_W{1'b0}};
                if (req_valid) begin
                    wr_d     = req_wr;
                    signed_d = req_signed;
                    size_d   = size_f(req_width);
                    addr_d   = req_paddr;
                    wstrb_d  = wstrb_f(req_wr, size_f(req_width), req_paddr[1:0]);
                    wdata_d  = wdata_f(size_f(req_width), req_wdata);
                    if (req_kill) begin
                        state_d = ST_IDLE;
                    end else if (misaligned_f(req_width, req_paddr[1:0])) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                to_d = to_q + TO_W'(1);
                // An address already accepted must still see its data phase.
                if (req_kill) begin
                    state_d = bus_addr_ok ? ST_DROP : ST_IDLE;
                end else if (timeout_s) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                end else if (bus_addr_ok) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                to_d = to_q + TO_W'(1);
                if (req_kill) begin
                    state_d = bus_data_ok ? ST_IDLE : ST_DROP;
                end else if (timeout_s) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                end else if (bus_data_ok) begin
                    state_d = ST_RESP;
                    err_d   = 1'b0;
                    rdata_d = wr_q ? 32'd0 : load_f(bus_rdata, addr_q[1:0], size_q, signed_q);
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_RESP: begin
                // Response fields are only meaningful during the pulse.
                state_d = ST_IDLE;
                err_d   = 1'b0;
                rdata_d = 32'd0;
            end
            ST_DROP: begin
                if (bus_data_ok) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
                rdata_d = 32'd0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wr_q     <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= 32'd0;
            wstrb_q  <= 4'd0;
            wdata_q  <= 32'd0;
            to_q     <= {TO_W{1'b0}};
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            signed_q <= signed_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            to_q     <= to_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_uncached_dbus_bridge.sv
// Directed testbench for uncached_dbus_bridge. Inputs change 1 time unit
// after the rising edge; outputs are sampled at that same point.
module tb_uncached_dbus_bridge;

    localparam int TB_TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic        req_signed = 1'b0;
    logic [1:0]  req_width = 2'b00;
    logic [31:0] req_paddr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_kill = 1'b0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok = 1'b0;
    logic        bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    int n_vec  = 0;
    int n_miss = 0;

    uncached_dbus_bridge #(.TIMEOUT_CYCLES(TB_TO), .TO_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_signed(req_signed), .req_width(req_width), .req_paddr(req_paddr),
        .req_wdata(req_wdata), .req_kill(req_kill),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic wr, input logic sgn, input logic [1:0] w,
                             input logic [31:0] a, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_wr     = wr;
        req_signed = sgn;
        req_width  = w;
        req_paddr  = a;
        req_wdata  = wd;
    endtask

    // Back-to-back transaction: accept, addr_ok next cycle, data_ok after.
    task automatic run_ok(input string tag, input logic wr, input logic sgn,
                          input logic [1:0] w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input logic [3:0] e_strb,
                          input logic [31:0] e_wdata, input logic [1:0] e_size,
                          input logic [31:0] e_rdata);
        drive_req(wr, sgn, w, a, wd);
        tick();
        req_valid = 1'b0;
        chk({tag, ".bus_req"}, 32'(bus_req), 32'd1);
        chk({tag, ".ready"},   32'(req_ready), 32'd0);
        chk({tag, ".addr"},    bus_addr, a);
        chk({tag, ".size"},    32'(bus_size), 32'(e_size));
        chk({tag, ".wr"},      32'(bus_wr), 32'(wr));
        chk({tag, ".wstrb"},   32'(bus_wstrb), 32'(e_strb));
        chk({tag, ".wdata"},   bus_wdata, e_wdata);
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        chk({tag, ".req_drop"}, 32'(bus_req), 32'd0);
        chk({tag, ".no_resp"},  32'(resp_valid), 32'd0);
        bus_data_ok = 1'b1;
        bus_rdata   = rd;
        tick();
        bus_data_ok = 1'b0;
        bus_rdata   = 32'hDEAD_BEEF;
        chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, ".resp_err"},   32'(resp_err), 32'd0);
        chk({tag, ".rdata"},      resp_rdata, e_rdata);
        tick();
        chk({tag, ".pulse_end"}, 32'(resp_valid), 32'd0);
        chk({tag, ".ready_again"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.bus_req", 32'(bus_req), 32'd0);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_err", 32'(resp_err), 32'd0);
        chk("rst.rdata", resp_rdata, 32'd0);
        chk("rst.wstrb", 32'(bus_wstrb), 32'd0);
        chk("rst.addr", bus_addr, 32'd0);
        chk("rst.wdata", bus_wdata, 32'd0);
        chk("rst.wr_size", {29'd0, bus_wr, bus_size}, 32'd0);
        #10;
        rst = 1'b0;
        tick();

        // Main function: loads and stores of every width and alignment
        run_ok("ldb_s3", 1'b0, 1'b1, 2'b00, 32'h1FD0_0003, 32'd0, 32'h80AA_BB00,
               4'b0000, 32'd0, 2'd0, 32'hFFFF_FF80);
        run_ok("sth_2",  1'b1, 1'b0, 2'b10, 32'h1FD0_0002, 32'h0000_1234, 32'hFFFF_FFFF,
               4'b1100, 32'h1234_1234, 2'd1, 32'd0);
        run_ok("stb_1",  1'b1, 1'b0, 2'b01, 32'h1FD0_0001, 32'h0000_00A5, 32'h1111_1111,
               4'b0010, 32'hA5A5_A5A5, 2'd0, 32'd0);
        run_ok("ldw_4",  1'b0, 1'b1, 2'b11, 32'h1FD0_0004, 32'd0, 32'h1234_5678,
               4'b0000, 32'd0, 2'd2, 32'h1234_5678);
        run_ok("ldhu_2", 1'b0, 1'b0, 2'b10, 32'h1FD0_0002, 32'd0, 32'h80AA_BB00,
               4'b0000, 32'd0, 2'd1, 32'h0000_80AA);
        run_ok("ldh_s0", 1'b0, 1'b1, 2'b10, 32'h1FD0_0000, 32'd0, 32'h80AA_BB00,
               4'b0000, 32'd0, 2'd1, 32'hFFFF_BB00);
        run_ok("ldbu_1", 1'b0, 1'b0, 2'b00, 32'h1FD0_0001, 32'd0, 32'h80AA_BB00,
               4'b0000, 32'd0, 2'd0, 32'h0000_00BB);
        run_ok("stw_8",  1'b1, 1'b0, 2'b11, 32'h1FD0_0008, 32'hCAFE_F00D, 32'd0,
               4'b1111, 32'hCAFE_F00D, 2'd2, 32'd0);

        // Misaligned word and half: error one cycle after accept, no bus_req
        drive_req(1'b0, 1'b0, 2'b11, 32'h1FD0_0006, 32'd0);
        bus_rdata = 32'h5555_5555;
        tick();
        req_valid = 1'b0;
        chk("misw.resp_valid", 32'(resp_valid), 32'd1);
        chk("misw.resp_err", 32'(resp_err), 32'd1);
        chk("misw.rdata", resp_rdata, 32'd0);
        chk("misw.bus_req", 32'(bus_req), 32'd0);
        tick();
        chk("misw.after", {30'd0, resp_valid, req_ready}, 32'd1);
        drive_req(1'b1, 1'b0, 2'b10, 32'h1FD0_0001, 32'h0000_BEEF);
        tick();
        req_valid = 1'b0;
        chk("mish.resp", {29'd0, bus_req, resp_valid, resp_err}, 32'd3);
        tick();

        // addr_ok withheld for 3 cycles: bus request holds steady
        drive_req(1'b0, 1'b0, 2'b11, 32'h1FD0_0010, 32'd0);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("hold.bus_req", 32'(bus_req), 32'd1);
            chk("hold.addr", bus_addr, 32'h1FD0_0010);
            chk("hold.size", 32'(bus_size), 32'd2);
            chk("hold.no_resp", 32'(resp_valid), 32'd0);
            if (i == 3) bus_addr_ok = 1'b1;
            tick();
        end
        bus_addr_ok = 1'b0;
        chk("hold.req_drop", 32'(bus_req), 32'd0);
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h0BAD_F00D;
        tick();
        bus_data_ok = 1'b0;
        chk("hold.resp", {30'd0, resp_valid, resp_err}, 32'd2);
        chk("hold.rdata", resp_rdata, 32'h0BAD_F00D);
        tick();
        chk("hold.single", 32'(resp_valid), 32'd0);

        // Stray data_ok in IDLE is ignored
        bus_data_ok = 1'b1;
        tick();
        bus_data_ok = 1'b0;
        chk("stray.idle", {30'd0, resp_valid, req_ready}, 32'd1);

        // Kill in DATA, data_ok two cycles later: silent drop
        drive_req(1'b0, 1'b0, 2'b11, 32'h1FD0_0020, 32'd0);
        tick();
        req_valid   = 1'b0;
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        req_kill    = 1'b1;
        tick();
        req_kill = 1'b0;
        chk("kdata.wait1", {29'd0, bus_req, resp_valid, req_ready}, 32'd0);
        tick();
        chk("kdata.wait2", {29'd0, bus_req, resp_valid, req_ready}, 32'd0);
        bus_data_ok = 1'b1;
        tick();
        bus_data_ok = 1'b0;
        chk("kdata.done", {30'd0, resp_valid, req_ready}, 32'd1);
        tick();
        chk("kdata.no_resp", 32'(resp_valid), 32'd0);

        // Kill in ADDR before addr_ok: back to IDLE, no response
        drive_req(1'b1, 1'b0, 2'b11, 32'h1FD0_0030, 32'h1234_5678);
        tick();
        req_valid = 1'b0;
        req_kill  = 1'b1;
        tick();
        req_kill = 1'b0;
        chk("kaddr.idle", {29'd0, bus_req, resp_valid, req_ready}, 32'd1);

        // Kill in the accept cycle: request discarded
        drive_req(1'b0, 1'b0, 2'b11, 32'h1FD0_0040, 32'd0);
        req_kill = 1'b1;
        tick();
        req_valid = 1'b0;
        req_kill  = 1'b0;
        chk("kacc.idle", {29'd0, bus_req, resp_valid, req_ready}, 32'd1);

        // Timeout: bus never answers
        drive_req(1'b0, 1'b0, 2'b11, 32'h1FD0_0050, 32'd0);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < TB_TO; i++) begin
            chk("to.waiting", {30'd0, bus_req, resp_valid}, 32'd2);
            tick();
        end
        chk("to.resp", {29'd0, bus_req, resp_valid, resp_err}, 32'd3);
        chk("to.rdata", resp_rdata, 32'd0);
        tick();
        bus_data_ok = 1'b1;
        tick();
        bus_data_ok = 1'b0;
        chk("to.stray", {30'd0, resp_valid, req_ready}, 32'd1);

        // Async reset in ADDR takes effect before the next edge
        drive_req(1'b0, 1'b0, 2'b11, 32'h1FD0_0060, 32'd0);
        tick();
        req_valid = 1'b0;
        chk("arst.pre", 32'(bus_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.now", {30'd0, bus_req, req_ready}, 32'd1);
        #1;
        rst = 1'b0;
        tick();
        chk("arst.after", {29'd0, bus_req, resp_valid, req_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
